// File: rtl/timebase_pkg.sv
// timebase_pkg: shared constants and types for the timebase sequencer.
//   TB_NUM_RATES : number of entries in the timebase table
//   TB_RATES     : divider terminal counts, index 0 = fastest rate
//   tb_state_t   : sequencer state (hold divider in reset / running)
//   tb_rate()    : table lookup, out-of-range indices clamp to the last entry
package timebase_pkg;

  localparam int unsigned TB_NUM_RATES = 8;
  localparam int unsigned TB_IW        = 3;

  // Packed so index 0 sits in the low word: entry i is TB_RATES[i].
  localparam logic [TB_NUM_RATES-1:0][31:0] TB_RATES = {
    32'd250, 32'd100, 32'd50, 32'd20, 32'd10, 32'd5, 32'd2, 32'd1
  };

  typedef enum logic {
    TB_HOLD = 1'b0,
    TB_RUN  = 1'b1
  } tb_state_t;

  function automatic logic [31:0] tb_rate(input logic [31:0] idx);
    if (idx < 32'(TB_NUM_RATES)) return TB_RATES[idx[TB_IW-1:0]];
    return TB_RATES[TB_NUM_RATES-1];
  endfunction

endpackage

// File: rtl/timebase_sequencer_tick_generator.sv
// tick_generator: free-running modulo counter producing a one-cycle strobe
// every count_i cycles while enabled.
//   inclk    : clock
//   Reset    : async active-low reset
//   enable_i : advance the counter this cycle (and allow tick_o)
//   clear_i  : force the counter back to 0 (wins over enable_i)
//   count_i  : period in cycles; 0 is treated as 1
//   tick_o   : high in the cycle the counter sits at count_i-1
module tick_generator (
  input  logic        inclk,
  input  logic        Reset,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [31:0] count_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] last;
  logic        at_last;

  // A zero period degenerates to a tick every cycle.
  assign last    = (count_i == 32'd0) ? 32'd0 : count_i - 32'd1;
  // >= keeps the counter from running away if the period ever shrinks.
  assign at_last = (cnt_q >= last);
  assign tick_o  = enable_i && !clear_i && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = 32'd0;
    else if (enable_i) cnt_d = at_last ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timebase_sequencer.sv
// timebase_sequencer: turns step_up/step_down requests into a divider
// terminal count from the timebase table, holding the divider in reset for
// HOLD_CYCLES cycles on every change, and emits a sample strobe aligned to
// the divider cadence.
//   inclk       : system / divider clock
//   Reset       : async active-low reset
//   step_up     : one-cycle request for the next slower rate
//   step_down   : one-cycle request for the next faster rate
//   div_count   : registered terminal count to the divider
//   div_reset_n : registered active-low divider reset
//   rate_index  : registered current table index
//   busy        : high while a hold sequence is in progress
//   sample_tick : one-cycle strobe every div_count cycles while running
module timebase_sequencer
  import timebase_pkg::*;
#(
  parameter int NUM_RATES   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int INIT_INDEX  = 0,
  localparam int IW = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
  input  logic          inclk,
  input  logic          Reset,
  input  logic          step_up,
  input  logic          step_down,
  output logic [31:0]   div_count,
  output logic          div_reset_n,
  output logic [IW-1:0] rate_index,
  output logic          busy,
  output logic          sample_tick
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  tb_state_t     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          drst_n_q, drst_n_d;
  logic          up_ok, dn_ok, accept;
  logic          run, tick;

  assign run    = (state_q == TB_RUN);
  // Simultaneous up/down cancel; saturate at both ends of the table.
  assign up_ok  = run && step_up && !step_down && (idx_q < IW'(NUM_RATES - 1));
  assign dn_ok  = run && step_down && !step_up && (idx_q != '0);
  assign accept = up_ok || dn_ok;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    drst_n_d = drst_n_q;
    unique case (state_q)
      TB_HOLD: begin
        drst_n_d = 1'b0;
        hold_d   = hold_q + HW'(1);
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d  = TB_RUN;
          drst_n_d = 1'b1;
          hold_d   = '0;
        end
      end
      TB_RUN: begin
        if (accept) begin
          idx_d    = up_ok ? idx_q + IW'(1) : idx_q - IW'(1);
          cnt_d    = tb_rate(32'(idx_d));
          state_d  = TB_HOLD;
          hold_d   = '0;
          drst_n_d = 1'b0;
        end
      end
      default: state_d = TB_HOLD;
    endcase
  end

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= TB_HOLD;
      idx_q    <= IW'(INIT_INDEX);
      cnt_q    <= tb_rate(32'(INIT_INDEX));
      hold_q   <= '0;
      drst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      drst_n_q <= drst_n_d;
    end
  end

  // Counter is cleared throughout HOLD so it restarts from 0 on release,
  // matching the divider; it is frozen in the cycle a request is accepted
  // so no strobe leaks out as the sequence starts.
  tick_generator u_tick (
    .inclk    (inclk),
    .Reset    (Reset),
    .enable_i (run && !accept),
    .clear_i  (!run),
    .count_i  (cnt_q),
    .tick_o   (tick)
  );

  assign div_count   = cnt_q;
  assign div_reset_n = drst_n_q;
  assign rate_index  = idx_q;
  assign busy        = !run;
  assign sample_tick = tick;

endmodule

// File: tb/tb_timebase_sequencer.sv
// Directed bench for timebase_sequencer with hand-computed expectations.
module tb_timebase_sequencer;

  logic        inclk = 1'b0;
  logic        Reset;
  logic        step_up, step_down;
  logic [31:0] div_count;
  logic        div_reset_n;
  logic [2:0]  rate_index;
  logic        busy, sample_tick;

  int checks = 0;
  int failures = 0;

  logic [31:0] rates [8] = '{32'd1, 32'd2, 32'd5, 32'd10, 32'd20, 32'd50, 32'd100, 32'd250};

  always #5 inclk = ~inclk;

  timebase_sequencer #(.NUM_RATES(8), .HOLD_CYCLES(4), .INIT_INDEX(0)) dut (
    .inclk       (inclk),
    .Reset       (Reset),
    .step_up     (step_up),
    .step_down   (step_down),
    .div_count   (div_count),
    .div_reset_n (div_reset_n),
    .rate_index  (rate_index),
    .busy        (busy),
    .sample_tick (sample_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge inclk);
    #1;
  endtask

  task automatic do_step(input logic up, input logic dn);
    step_up = up; step_down = dn;
    cyc();
    step_up = 1'b0; step_down = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) cyc();
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    Reset = 1'b0; step_up = 1'b0; step_down = 1'b0;
    cyc(); cyc();
    chk("rst_rstn", div_reset_n, 0);
    chk("rst_busy", busy, 1);
    chk("rst_idx", rate_index, 0);
    chk("rst_cnt", div_count, 1);
    chk("rst_tick", sample_tick, 0);

    // Release: divider held through edges 1..3, released at edge 4.
    Reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("rel_hold_rstn", div_reset_n, 0);
      chk("rel_hold_tick", sample_tick, 0);
    end
    cyc();
    chk("rel_rstn", div_reset_n, 1);
    chk("rel_busy", busy, 0);
    chk("rel_tick0", sample_tick, 1);
    cyc();
    chk("rel_tick1", sample_tick, 1);

    // step_up at index 0.
    do_step(1'b1, 1'b0);
    chk("up0_idx", rate_index, 1);
    chk("up0_cnt", div_count, 2);
    chk("up0_rstn", div_reset_n, 0);
    chk("up0_busy", busy, 1);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk("up0_hold_rstn", div_reset_n, 0);
    end
    cyc();
    chk("up0_release", div_reset_n, 1);
    chk("up0_tick_r", sample_tick, 0);
    cyc(); chk("up0_tick_a", sample_tick, 1);
    cyc(); chk("up0_tick_b", sample_tick, 0);
    cyc(); chk("up0_tick_c", sample_tick, 1);

    // Walk up to the top of the table.
    for (int i = 2; i <= 7; i++) begin
      do_step(1'b1, 1'b0);
      chk("walk_idx", rate_index, i);
      chk("walk_cnt", div_count, rates[i]);
      wait_idle();
    end
    chk("top_cnt", div_count, 250);
    do_step(1'b1, 1'b0);
    chk("sat_up_idx", rate_index, 7);
    chk("sat_up_busy", busy, 0);
    chk("sat_up_rstn", div_reset_n, 1);
    cyc();
    chk("sat_up_busy2", busy, 0);

    // Down to index 3, then both at once.
    for (int i = 6; i >= 3; i--) begin
      do_step(1'b0, 1'b1);
      chk("down_idx", rate_index, i);
      chk("down_cnt", div_count, rates[i]);
      wait_idle();
    end
    do_step(1'b1, 1'b1);
    chk("both_idx", rate_index, 3);
    chk("both_busy", busy, 0);
    chk("both_rstn", div_reset_n, 1);

    for (int i = 2; i >= 0; i--) begin
      do_step(1'b0, 1'b1);
      wait_idle();
    end
    chk("at0_idx", rate_index, 0);
    do_step(1'b0, 1'b1);
    chk("sat_dn_idx", rate_index, 0);
    chk("sat_dn_busy", busy, 0);
    chk("sat_dn_cnt", div_count, 1);

    // Strobe suppressed in the cycle a request is accepted (dc=1 would tick).
    step_up = 1'b1;
    #1;
    chk("accept_tick", sample_tick, 0);
    cyc();
    step_up = 1'b0;
    // Request during the second hold cycle is dropped.
    do_step(1'b1, 1'b0);
    chk("drop_busy", busy, 1);
    wait_idle();
    chk("drop_idx", rate_index, 1);
    chk("drop_cnt", div_count, 2);

    // Climb to index 5, then assert reset mid-cycle.
    for (int i = 2; i <= 5; i++) begin
      do_step(1'b1, 1'b0);
      wait_idle();
    end
    chk("pre_rst_idx", rate_index, 5);
    cyc();
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_idx", rate_index, 0);
    chk("arst_cnt", div_count, 1);
    chk("arst_rstn", div_reset_n, 0);
    chk("arst_tick", sample_tick, 0);
    chk("arst_busy", busy, 1);
    cyc();
    Reset = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timebase_sequencer.md
# timebase_sequencer

Controller for the oscilloscope's programmable clock divider. It turns user step requests into a divider terminal count from a fixed timebase table. Every change goes through a clean hold/release sequence: the divider is held in reset while its count changes, so no runt or stretched output phase ever appears. It also produces a one-cycle sample strobe aligned to the divider's toggle cadence for the capture logic.

## Interface
Parameters:
- NUM_RATES, 8, number of timebase table entries (index width = $clog2(NUM_RATES)).
- HOLD_CYCLES, 4, cycles the divider reset is held low on every change (≥1).
- INIT_INDEX, 0, table index loaded at reset.

Ports:
- inclk  in  1  system clock, same clock that drives the divider.
- Reset  in  1  reset, asynchronous, active-low.
- step_up  in  1  single-cycle request: move to next slower rate (index+1).
- step_down  in  1  single-cycle request: move to next faster rate (index−1).
- div_count  out  32  terminal count driven to divider's count input.
- div_reset_n  out  1  active-low reset driven to divider.
- rate_index  out  IW  current table index.
- busy  out  1  high while a change sequence is in progress.
- sample_tick  out  1  one-cycle pulse every div_count inclk cycles while running.

## Operation
- States: HOLD, RUN.
- Reset (async, Reset=0): state=HOLD, rate_index=INIT_INDEX, div_count=TB_RATES[INIT_INDEX], div_reset_n=0, busy=1, hold counter=0, tick counter=0, sample_tick=0.
- HOLD:
  - div_reset_n=0, busy=1; hold counter increments each cycle.
  - When hold counter reaches HOLD_CYCLES−1: next cycle state=RUN, div_reset_n=1, busy=0, tick counter=0.
  - step_up/step_down during HOLD are dropped (not queued).
- RUN, request handling:
  - step_up alone with rate_index<NUM_RATES−1 → index+1.
  - step_down alone with rate_index>0 → index−1.
  - An accepted request loads div_count=TB_RATES[new index], enters HOLD, clears the hold counter.
  - Saturating, no wrap: step_up at max index and step_down at index 0 are ignored; state stays RUN, no hold sequence.
  - step_up and step_down in the same cycle: ignored.
- RUN, sample_tick:
  - Tick counter counts 0..div_count−1 then wraps to 0.
  - sample_tick=1 in the cycle the counter equals div_count−1.
  - A div_count of 0 is treated as 1, giving a tick every cycle. The table never contains 0; the guard is still required.
- sample_tick is 0 in HOLD and in the cycle an accepted request leaves RUN.
- div_count, rate_index and div_reset_n are registered outputs; no combinational path from the step inputs.

## Timing
- Accepted request sampled at edge N: at N+1 rate_index and div_count are new, div_reset_n=0, busy=1.
- div_reset_n stays low for exactly HOLD_CYCLES cycles (N+1..N+HOLD_CYCLES) and returns high at N+HOLD_CYCLES+1.
- First sample_tick after release: div_count cycles after release, i.e. at N+HOLD_CYCLES+div_count.
- After reset deassertion: divider released after HOLD_CYCLES cycles.
- Reset mid-sequence: immediate async return to reset values, including index=INIT_INDEX.
- Latency from request to new count visible at divider: 1 cycle. Divider output resumes from 0 after release.

## Structure
- Shared package timebase_pkg: TB_NUM_RATES constant, TB_RATES localparam array of 32-bit counts {1,2,5,10,20,50,100,250}, state enum tb_state_t {TB_HOLD, TB_RUN}.
- Natural sub-module: tick_generator (counter + sample_tick, inputs enable/clear/count). The FSM and table lookup stay in the top.
- The sequencer instantiates nothing from the divider. The integration level wires div_count/div_reset_n to the divider's count and reset inputs.

## Test plan
- Reset release, INIT_INDEX=0: div_reset_n low 4 cycles then high; div_count=1; busy falls with release; sample_tick every cycle thereafter.
- step_up pulse in RUN at index 0: next cycle index=1, div_count=2, div_reset_n low 4 cycles; first sample_tick 2 cycles after release, then every 2 cycles.
- Seven step_up pulses, each issued after busy falls: index reaches 7, div_count=250. An eighth step_up leaves index=7, busy never rises, div_reset_n stays 1.
- step_down at index 0 → no change. step_up and step_down in same cycle at index 3 → no change, no hold.
- step_up issued while busy=1 (2nd hold cycle) → dropped; index advances by one only.
- Reset asserted at index 5 mid-RUN → asynchronously index=0, div_count=1, div_reset_n=0, sample_tick=0.
